// File: rtl/lpc_frame_decoder.sv
// LPC bus frame decoder: samples LAD/LFRAME# and reports completed I/O and memory
// read/write cycles as cyctype/address/data, qualified by a multi-cycle latch strobe.
module lpc_frame_decoder #(
  parameter int unsigned LATCH_CYCLES = 2,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  lpc_cyctype_dir,
  output logic [31:0] lpc_addr,
  output logic [7:0]  lpc_data,
  output logic        lpc_latch,
  output logic        lpc_frame_error
);

  localparam int unsigned NIB_W  = 3;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned LCNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_CYCTYPE, S_ADDR, S_WDATA, S_WTAR,
    S_WSYNC, S_RTAR, S_RSYNC, S_RDATA, S_LATCH
  } state_t;

  state_t              state, state_d;
  logic [NIB_W-1:0]    nib_cnt, nib_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [WAIT_W-1:0]   wait_inc;
  logic [3:0]          cyctype, cyctype_d;
  logic [31:0]         addr, addr_d;
  logic [7:0]          data, data_d;
  logic                err_d;
  logic                pend, pend_d;
  logic [LCNT_W-1:0]   lcnt;
  logic [NIB_W-1:0]    last_nib;

  assign wait_inc = wait_cnt + WAIT_W'(1);
  assign last_nib = cyctype[2] ? NIB_W'(7) : NIB_W'(3);

  // Frame state and capture registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      nib_cnt         <= '0;
      wait_cnt        <= '0;
      cyctype         <= '0;
      addr            <= '0;
      data            <= '0;
      pend            <= 1'b0;
      lpc_frame_error <= 1'b0;
    end else begin
      state           <= state_d;
      nib_cnt         <= nib_cnt_d;
      wait_cnt        <= wait_cnt_d;
      cyctype         <= cyctype_d;
      addr            <= addr_d;
      data            <= data_d;
      pend            <= pend_d;
      lpc_frame_error <= err_d;
    end
  end

  // Next-state and capture logic; LFRAME# low overrides every state
  always_comb begin
    state_d    = state;
    nib_cnt_d  = nib_cnt;
    wait_cnt_d = wait_cnt;
    cyctype_d  = cyctype;
    addr_d     = addr;
    data_d     = data;
    err_d      = 1'b0;
    pend_d     = 1'b0;
    if (!lpc_frame) begin
      state_d = (lpc_ad == 4'h0) ? S_CYCTYPE : S_IDLE;
      err_d   = (state != S_IDLE) && (state != S_CYCTYPE) && (state != S_LATCH);
    end else begin
      case (state)
        S_CYCTYPE: begin
          cyctype_d = {lpc_ad[3:1], 1'b0};
          if (lpc_ad[3]) begin
            state_d = S_IDLE;
          end else begin
            addr_d    = '0;
            nib_cnt_d = '0;
            state_d   = S_ADDR;
          end
        end
        S_ADDR: begin
          addr_d    = {addr[27:0], lpc_ad};
          nib_cnt_d = nib_cnt + NIB_W'(1);
          if (nib_cnt == last_nib) begin
            nib_cnt_d = '0;
            state_d   = cyctype[1] ? S_WDATA : S_RTAR;
          end
        end
        S_WDATA, S_RDATA: begin
          if (nib_cnt == '0) begin
            data_d    = {data[7:4], lpc_ad};
            nib_cnt_d = NIB_W'(1);
          end else begin
            data_d    = {lpc_ad, data[3:0]};
            nib_cnt_d = '0;
            if (state == S_WDATA) begin
              state_d = S_WTAR;
            end else begin
              state_d = S_LATCH;
              pend_d  = 1'b1;
            end
          end
        end
        S_WTAR, S_RTAR: begin
          wait_cnt_d = '0;
          if (nib_cnt == '0) begin
            nib_cnt_d = NIB_W'(1);
          end else begin
            nib_cnt_d = '0;
            state_d   = (state == S_WTAR) ? S_WSYNC : S_RSYNC;
          end
        end
        S_WSYNC, S_RSYNC: begin
          case (lpc_ad)
            4'h0: begin
              nib_cnt_d = '0;
              if (state == S_WSYNC) begin
                state_d = S_LATCH;
                pend_d  = 1'b1;
              end else begin
                state_d = S_RDATA;
              end
            end
            4'h5, 4'h6: begin
              wait_cnt_d = wait_inc;
              if (wait_inc == WAIT_W'(SYNC_TIMEOUT)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_LATCH: begin
          if (lcnt == LCNT_W'(LATCH_CYCLES)) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Output registers load one cycle after LATCH entry; the strobe count runs on its own
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lpc_cyctype_dir <= '0;
      lpc_addr        <= '0;
      lpc_data        <= '0;
      lpc_latch       <= 1'b0;
      lcnt            <= '0;
    end else if (pend) begin
      lpc_cyctype_dir <= cyctype;
      lpc_addr        <= addr;
      lpc_data        <= data;
      lpc_latch       <= 1'b1;
      lcnt            <= LCNT_W'(1);
    end else if (lcnt != '0) begin
      if (lcnt == LCNT_W'(LATCH_CYCLES)) begin
        lcnt      <= '0;
        lpc_latch <= 1'b0;
      end else begin
        lcnt <= lcnt + LCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lpc_frame_decoder.sv
// Bench for lpc_frame_decoder: frame-level reference model scheduling expected
// latch/error/output events per edge, directed scenarios plus randomized frames.
module tb_lpc_frame_decoder;

  localparam int unsigned LATCH_CYCLES = 2;
  localparam int unsigned SYNC_TIMEOUT = 16;
  localparam int N = 16384;
  localparam int K_GOOD = 0, K_SYNCERR = 1, K_TIMEOUT = 2, K_ABORT = 3, K_DMA = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  lpc_ad = 4'hF;
  logic        lpc_frame = 1'b1;
  logic [3:0]  lpc_cyctype_dir;
  logic [31:0] lpc_addr;
  logic [7:0]  lpc_data;
  logic        lpc_latch;
  logic        lpc_frame_error;

  lpc_frame_decoder #(.LATCH_CYCLES(LATCH_CYCLES), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .lpc_cyctype_dir(lpc_cyctype_dir), .lpc_addr(lpc_addr), .lpc_data(lpc_data),
    .lpc_latch(lpc_latch), .lpc_frame_error(lpc_frame_error)
  );

  always #5 clock = ~clock;

  int ecount = 0;
  always @(posedge clock) ecount <= ecount + 1;

  // Expected events per edge index; ld holds {cyctype_dir, addr, data}
  bit          exp_latch [N];
  bit          exp_err   [N];
  bit          exp_load  [N];
  logic [43:0] ld        [N];
  bit          act_latch [N];
  bit          act_err   [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  // Per-cycle comparison against the scheduled model
  initial begin
    logic [43:0] cur;
    cur = '0;
    forever begin
      @(posedge clock);
      #1;
      if (ecount < N) begin
        act_latch[ecount] = lpc_latch;
        act_err[ecount]   = lpc_frame_error;
        if (!reset) cur = '0;
        else if (exp_load[ecount]) cur = ld[ecount];
        chk("latch", 32'(lpc_latch), 32'(exp_latch[ecount]));
        chk("frame_error", 32'(lpc_frame_error), 32'(exp_err[ecount]));
        chk("cyctype_dir", 32'(lpc_cyctype_dir), 32'(cur[43:40]));
        chk("addr", lpc_addr, cur[39:8]);
        chk("data", 32'(lpc_data), 32'(cur[7:0]));
      end
    end
  end

  task automatic drv(input logic f, input logic [3:0] ad, output int e);
    @(negedge clock);
    lpc_frame = f;
    lpc_ad    = ad;
    e         = ecount + 1;
  endtask

  task automatic gap(input int n);
    int e;
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) drv(1'b0, 4'($urandom_range(1, 15)), e);
      else drv(1'b1, 4'($urandom), e);
    end
  endtask

  // Builds a frame as a nibble list, schedules its expected effects, then drives it
  task automatic run_frame(input int kind, input bit mem, input bit wr,
                           input logic [31:0] a, input logic [7:0] d,
                           input int waits, input int trail, input int abort_at,
                           input logic [3:0] bad, output int s);
    logic [4:0] q[$];
    int err_idx, last_idx, e, n, ab;
    logic [3:0] b;
    err_idx = -1;
    last_idx = -1;
    s = 0;
    q.push_back(5'h00);
    if (kind == K_DMA) begin
      q.push_back({1'b1, 1'b1, 3'($urandom)});
      repeat (2) q.push_back({1'b1, 4'($urandom)});
    end else begin
      q.push_back({1'b1, 1'b0, mem, wr, 1'($urandom)});
      n = mem ? 8 : 4;
      for (int i = n - 1; i >= 0; i--) q.push_back({1'b1, a[4*i +: 4]});
      if (wr) begin
        q.push_back({1'b1, d[3:0]});
        q.push_back({1'b1, d[7:4]});
      end
      repeat (2) q.push_back({1'b1, 4'($urandom)});
      for (int i = 0; i < ((kind == K_TIMEOUT) ? int'(SYNC_TIMEOUT) : waits); i++)
        q.push_back({1'b1, ($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6});
      if (kind == K_TIMEOUT) begin
        err_idx = q.size() - 1;
      end else if (kind == K_SYNCERR) begin
        b = bad;
        while (b == 4'h0 || b == 4'h5 || b == 4'h6) b = 4'($urandom);
        q.push_back({1'b1, b});
        err_idx = q.size() - 1;
      end else begin
        q.push_back(5'h10);
        if (!wr) begin
          q.push_back({1'b1, d[3:0]});
          q.push_back({1'b1, d[7:4]});
        end
        last_idx = q.size() - 1;
        if (kind == K_ABORT) begin
          ab = abort_at;
          if (ab < 2 || ab > last_idx) ab = $urandom_range(2, last_idx);
          while (q.size() > ab) void'(q.pop_back());
          b = (bad == 4'h0) ? 4'($urandom_range(1, 15)) : bad;
          q.push_back({1'b0, b});
          err_idx  = ab;
          last_idx = -1;
        end else begin
          repeat (trail) q.push_back({1'b1, 4'($urandom)});
        end
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      drv(q[i][4], q[i][3:0], e);
      if (i == 0) begin
        s = e;
        if (err_idx >= 0 && s + err_idx < N) exp_err[s + err_idx] = 1'b1;
        if (last_idx >= 0 && s + last_idx + int'(LATCH_CYCLES) < N) begin
          exp_load[s + last_idx + 1] = 1'b1;
          ld[s + last_idx + 1] = {1'b0, mem, wr, 1'b0, (mem ? a : {16'h0, a[15:0]}), d};
          for (int k = 1; k <= int'(LATCH_CYCLES); k++) exp_latch[s + last_idx + k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int s, e, kind;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_addr", lpc_addr, 32'h0);
    chk("reset_latch", 32'(lpc_latch), 32'h0);

    // I/O write 0x0080 <- 0x5A
    run_frame(K_GOOD, 1'b0, 1'b1, 32'h0080, 8'h5A, 0, 4, 0, 4'h0, s);
    chk("iow_latch_n10", 32'(act_latch[s+10]), 32'h0);
    chk("iow_latch_n11", 32'(act_latch[s+11]), 32'h1);
    chk("iow_latch_n12", 32'(act_latch[s+12]), 32'h1);
    chk("iow_latch_n13", 32'(act_latch[s+13]), 32'h0);
    chk("iow_cyc", 32'(lpc_cyctype_dir), 32'h2);
    chk("iow_addr", lpc_addr, 32'h00000080);
    chk("iow_data", 32'(lpc_data), 32'h5A);
    gap(2);

    // Memory read 0xFFFFFFF0 with 3 wait SYNCs
    run_frame(K_GOOD, 1'b1, 1'b0, 32'hFFFFFFF0, 8'hC3, 3, 3, 0, 4'h0, s);
    chk("mrd_latch_17", 32'(act_latch[s+17]), 32'h0);
    chk("mrd_latch_18", 32'(act_latch[s+18]), 32'h1);
    chk("mrd_cyc", 32'(lpc_cyctype_dir), 32'h4);
    chk("mrd_addr", lpc_addr, 32'hFFFFFFF0);
    chk("mrd_data", 32'(lpc_data), 32'hC3);
    gap(1);

    // SYNC error: outputs keep the previous frame
    run_frame(K_SYNCERR, 1'b0, 1'b1, 32'h0080, 8'h11, 0, 0, 0, 4'hA, s);
    gap(2);
    chk("serr_err", 32'(act_err[s+10]), 32'h1);
    chk("serr_noerr_before", 32'(act_err[s+9]), 32'h0);
    chk("serr_nolatch", 32'(act_latch[s+11]), 32'h0);
    chk("serr_addr_hold", lpc_addr, 32'hFFFFFFF0);
    chk("serr_data_hold", 32'(lpc_data), 32'hC3);

    // SYNC timeout, then a clean frame
    run_frame(K_TIMEOUT, 1'b0, 1'b0, 32'h1234, 8'h00, 0, 0, 0, 4'h0, s);
    gap(2);
    chk("tmo_err", 32'(act_err[s+23]), 32'h1);
    chk("tmo_err_early", 32'(act_err[s+22]), 32'h0);
    run_frame(K_GOOD, 1'b0, 1'b1, 32'h0070, 8'h11, 1, 2, 0, 4'h0, s);
    gap(1);
    chk("tmo_next_addr", lpc_addr, 32'h00000070);
    chk("tmo_next_data", 32'(lpc_data), 32'h11);

    // Abort after second address nibble, then I/O read 0x0060
    run_frame(K_ABORT, 1'b0, 1'b1, 32'h0000, 8'h00, 0, 0, 4, 4'hF, s);
    gap(1);
    chk("abort_err", 32'(act_err[s+4]), 32'h1);
    run_frame(K_GOOD, 1'b0, 1'b0, 32'h0060, 8'hAA, 0, 2, 0, 4'h0, s);
    gap(1);
    chk("ior_cyc", 32'(lpc_cyctype_dir), 32'h0);
    chk("ior_addr", lpc_addr, 32'h00000060);
    chk("ior_data", 32'(lpc_data), 32'hAA);

    // DMA frame, then reset in the middle of a memory write
    run_frame(K_DMA, 1'b0, 1'b0, 32'h0, 8'h0, 0, 0, 0, 4'h0, s);
    drv(1'b0, 4'h0, e);
    drv(1'b1, 4'h6, e);
    repeat (3) drv(1'b1, 4'($urandom), e);
    reset = 1'b0;
    repeat (2) drv(1'b1, 4'hF, e);
    reset = 1'b1;
    gap(3);
    chk("rst_addr", lpc_addr, 32'h0);
    chk("rst_data", 32'(lpc_data), 32'h0);
    chk("rst_cyc", 32'(lpc_cyctype_dir), 32'h0);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      kind = (kind <= 5) ? K_GOOD : (kind == 6) ? K_SYNCERR : (kind == 7) ? K_TIMEOUT :
             (kind == 8) ? K_ABORT : K_DMA;
      run_frame(kind, 1'($urandom), 1'($urandom), $urandom, 8'($urandom),
                ($urandom_range(0, 7) == 0) ? int'(SYNC_TIMEOUT) - 1 : $urandom_range(0, 3),
                $urandom_range(0, 2), 0, 4'h0, s);
      gap($urandom_range(0, 3));
    end
    gap(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
